// File: rtl/gpio_irq_if.sv
// Memory-bus slave port of the GPIO block: select, request, write data, response.
// Latency: none of its own; carries the single-cycle request/ready handshake.
// Backpressure: master holds the request stable until it sees the one-cycle mem_ready pulse.
//
// Signals: mem_sel (decoder select), mem_valid, mem_wr, mem_addr[11:0], mem_wdata[31:0]
// from the master; mem_ready (one-cycle pulse) and mem_rdata[31:0] from the slave.
interface gpio_irq_if;
    logic        mem_sel;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_wr;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output mem_sel,
        output mem_valid,
        output mem_wr,
        output mem_addr,
        output mem_wdata,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_sel,
        input  mem_valid,
        input  mem_wr,
        input  mem_addr,
        input  mem_wdata,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/gpio_irq.sv
// GPIO peripheral: per-pin direction, atomic set/clear/toggle, synchronised inputs, edge IRQs.
// Latency: register access completes 1 cycle after request; input -> DIN after SYNC_STAGES edges.
// Backpressure: one access per 2 cycles; mem_ready is a single pulse, no stalls beyond that.
//
// Ports: clk, reset (async, active-high); bus (gpio_irq_if.slave memory port);
// gpio_oe/gpio_do (pin drive enable and data), gpio_di (raw async pin input);
// irq (registered level interrupt = any enabled sticky edge flag).
module gpio_irq #(
    parameter int                  NR_GPIOS    = 8,
    parameter int                  SYNC_STAGES = 2,
    parameter logic [NR_GPIOS-1:0] DOUT_RESET  = '0
) (
    input  logic                clk,
    input  logic                reset,
    gpio_irq_if.slave           bus,
    output logic [NR_GPIOS-1:0] gpio_oe,
    output logic [NR_GPIOS-1:0] gpio_do,
    input  logic [NR_GPIOS-1:0] gpio_di,
    output logic                irq
);

    // Word index = byte offset >> 2
    localparam logic [4:0] REG_OE     = 5'h00;
    localparam logic [4:0] REG_DOUT   = 5'h01;
    localparam logic [4:0] REG_SET    = 5'h02;
    localparam logic [4:0] REG_CLR    = 5'h03;
    localparam logic [4:0] REG_TGL    = 5'h04;
    localparam logic [4:0] REG_DIN    = 5'h05;
    localparam logic [4:0] REG_EN     = 5'h06;
    localparam logic [4:0] REG_RISE   = 5'h07;
    localparam logic [4:0] REG_FALL   = 5'h08;
    localparam logic [4:0] REG_STATUS = 5'h09;

    // Edge detection stays disabled until the sync chain and din_p hold real
    // pin values, so pins that sit high through reset do not look like edges.
    localparam int ARM_CYCLES = SYNC_STAGES + 1;
    localparam int ARM_W      = $clog2(ARM_CYCLES + 1);

    logic [NR_GPIOS-1:0] sync_q [SYNC_STAGES];
    logic [NR_GPIOS-1:0] din_s;
    logic [NR_GPIOS-1:0] din_p;
    logic [ARM_W-1:0]    arm_cnt;
    logic                armed;

    logic [NR_GPIOS-1:0] irq_en;
    logic [NR_GPIOS-1:0] irq_rise;
    logic [NR_GPIOS-1:0] irq_fall;
    logic [NR_GPIOS-1:0] irq_status;

    logic                start;
    logic                wr_en;
    logic [4:0]          reg_idx;
    logic [NR_GPIOS-1:0] wd;
    logic [NR_GPIOS-1:0] edge_hit;
    logic [NR_GPIOS-1:0] w1c;
    logic [31:0]         rd_mux;
    logic                unused_bits;

    assign din_s   = sync_q[SYNC_STAGES-1];
    assign armed   = (arm_cnt == ARM_W'(ARM_CYCLES));
    assign reg_idx = bus.mem_addr[6:2];
    assign wd      = bus.mem_wdata[NR_GPIOS-1:0];

    // mem_ready gates a new start so each held request produces exactly one pulse
    assign start = bus.mem_valid & bus.mem_sel & ~bus.mem_ready;
    assign wr_en = start & bus.mem_wr;

    assign edge_hit = armed ? ((din_s & ~din_p & irq_rise) | (~din_s & din_p & irq_fall))
                            : '0;
    assign w1c      = (wr_en && reg_idx == REG_STATUS) ? wd : '0;

    assign unused_bits = ^{bus.mem_addr[11:7], bus.mem_addr[1:0], bus.mem_wdata};

    always_comb begin
        rd_mux = '0;
        case (reg_idx)
            REG_OE:     rd_mux[NR_GPIOS-1:0] = gpio_oe;
            REG_DOUT:   rd_mux[NR_GPIOS-1:0] = gpio_do;
            REG_DIN:    rd_mux[NR_GPIOS-1:0] = din_s;
            REG_EN:     rd_mux[NR_GPIOS-1:0] = irq_en;
            REG_RISE:   rd_mux[NR_GPIOS-1:0] = irq_rise;
            REG_FALL:   rd_mux[NR_GPIOS-1:0] = irq_fall;
            REG_STATUS: rd_mux[NR_GPIOS-1:0] = irq_status;
            default:    rd_mux = '0;
        endcase
    end

    // Input synchroniser, previous-value register and arm counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            din_p   <= '0;
            arm_cnt <= '0;
        end else begin
            sync_q[0] <= gpio_di;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            din_p <= din_s;
            if (!armed) begin
                arm_cnt <= arm_cnt + 1'b1;
            end
        end
    end

    // Bus response, registers and interrupt state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.mem_ready <= 1'b0;
            bus.mem_rdata <= '0;
            gpio_oe       <= '0;
            gpio_do       <= DOUT_RESET;
            irq_en        <= '0;
            irq_rise      <= '0;
            irq_fall      <= '0;
            irq_status    <= '0;
            irq           <= 1'b0;
        end else begin
            bus.mem_ready <= start;
            if (start && !bus.mem_wr) begin
                bus.mem_rdata <= rd_mux;
            end
            if (wr_en) begin
                case (reg_idx)
                    REG_OE:   gpio_oe  <= wd;
                    REG_DOUT: gpio_do  <= wd;
                    REG_SET:  gpio_do  <= gpio_do | wd;
                    REG_CLR:  gpio_do  <= gpio_do & ~wd;
                    REG_TGL:  gpio_do  <= gpio_do ^ wd;
                    REG_EN:   irq_en   <= wd;
                    REG_RISE: irq_rise <= wd;
                    REG_FALL: irq_fall <= wd;
                    default:  ;
                endcase
            end
            // A new edge beats a simultaneous write-one-to-clear on the same bit
            irq_status <= (irq_status & ~w1c) | edge_hit;
            irq        <= |(irq_status & irq_en);
        end
    end

endmodule
